// File: rtl/av1_intra_pkg.sv
// Shared types and constants for the AV1 intra edge upsample stage.
package av1_intra_pkg;

  typedef enum logic [1:0] {IDLE, DECIDE, LOAD, EMIT} ups_state_t;

  localparam int unsigned UPS_DELTA_MAX    = 40;
  localparam int unsigned UPS_BLKWH_SMOOTH = 8;
  localparam int unsigned UPS_BLKWH_SHARP  = 16;

  function automatic logic signed [31:0] clip_pixel(input logic signed [31:0] v,
                                                    input int unsigned bitdepth);
    logic signed [31:0] maxv;
    maxv = (32'sd1 <<< bitdepth) - 32'sd1;
    if (v < 32'sd0) return '0;
    if (v > maxv) return maxv;
    return v;
  endfunction

endpackage

// File: rtl/intra_upsample_filter.sv
// Combinational 4-tap (-1, 9, 9, -1) upsample filter with Round2(.,4) and pixel clip.
module intra_upsample_filter
  import av1_intra_pkg::*;
#(
  parameter int unsigned BITDEPTH = 10
) (
  input  logic [BITDEPTH-1:0] p0,
  input  logic [BITDEPTH-1:0] p1,
  input  logic [BITDEPTH-1:0] p2,
  input  logic [BITDEPTH-1:0] p3,
  output logic [BITDEPTH-1:0] y
);

  localparam int unsigned SW = BITDEPTH + 6;
  localparam logic signed [SW-1:0] NINE  = SW'(9);
  localparam logic signed [SW-1:0] EIGHT = SW'(8);

  logic signed [SW-1:0] a, b, c, d;
  logic signed [SW-1:0] sum, rnd;

  always_comb begin
    a   = signed'({6'b0, p0});
    b   = signed'({6'b0, p1});
    c   = signed'({6'b0, p2});
    d   = signed'({6'b0, p3});
    sum = NINE * b + NINE * c - a - d;
    rnd = (sum + EIGHT) >>> 4;
    y   = BITDEPTH'(clip_pixel(32'(rnd), BITDEPTH));
  end

endmodule

// File: rtl/intra_edge_upsampler.sv
// AV1 intra edge upsampler: decides useUpsample, buffers one edge, then streams
// either the 2x upsampled edge or the unmodified edge with valid/ready handshake.
module intra_edge_upsampler
  import av1_intra_pkg::*;
#(
  parameter int unsigned BITDEPTH  = 10,
  parameter int unsigned MAX_NUMPX = 32,
  parameter int unsigned DIM_W     = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                filterType,
  input  logic [DIM_W-1:0]    w,
  input  logic [DIM_W-1:0]    h,
  input  logic [DIM_W-1:0]    delta,
  input  logic [DIM_W-1:0]    numPx,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITDEPTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITDEPTH-1:0] out_data,
  output logic                out_last,
  output logic                useUpsample,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned KW   = DIM_W + 1;
  localparam int unsigned NENT = MAX_NUMPX + 1;
  localparam int unsigned IW   = $clog2(NENT);
  localparam logic [KW-1:0] MAXN = KW'(MAX_NUMPX);

  ups_state_t          state_q, state_d;
  logic                ft_q, ft_d;
  logic [DIM_W-1:0]    w_q, w_d, h_q, h_d, delta_q, delta_d, numpx_q, numpx_d;
  logic                use_up_q, use_up_d;
  logic [KW-1:0]       cnt_q, cnt_d, k_q, k_d;
  logic [BITDEPTH-1:0] buf_q [NENT];
  logic [BITDEPTH-1:0] buf_d [NENT];
  logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [BITDEPTH-1:0] out_data_q, out_data_d;
  logic                in_ready_q, in_ready_d, busy_q, busy_d;
  logic                done_q, done_d, err_q, err_d;

  // Decision
  logic [KW-1:0] delta_ext, delta_abs, blk_wh, blk_lim;
  logic          decide_up;

  always_comb begin
    delta_ext = {delta_q[DIM_W-1], delta_q};
    delta_abs = delta_ext[KW-1] ? (~delta_ext + 1'b1) : delta_ext;
    blk_wh    = {1'b0, w_q} + {1'b0, h_q};
    blk_lim   = ft_q ? KW'(UPS_BLKWH_SMOOTH) : KW'(UPS_BLKWH_SHARP);
    decide_up = (delta_abs != '0) && (delta_abs < KW'(UPS_DELTA_MAX)) && (blk_wh <= blk_lim);
  end

  // Sample for the next output index: k+1 while emitting, 0 when entering EMIT.
  // Edge indices are clamped to [0, numPx], which realises the duplicated end taps.
  logic [KW-1:0]       numpx_ext, last_k, sel_k, half;
  logic [KW-1:0]       tap_m1, tap_0, tap_p1, tap_p2, pass_idx;
  logic [BITDEPTH-1:0] p0_s, p1_s, p2_s, p3_s, filt_y, next_sample;

  always_comb begin
    numpx_ext   = {1'b0, numpx_q};
    last_k      = use_up_q ? {numpx_q, 1'b0} : numpx_ext;
    sel_k       = (state_q == EMIT) ? k_q + 1'b1 : '0;
    half        = sel_k >> 1;
    tap_m1      = (half == '0) ? '0 : half - 1'b1;
    tap_0       = (half > numpx_ext) ? numpx_ext : half;
    tap_p1      = ((half + 1'b1) > numpx_ext) ? numpx_ext : half + 1'b1;
    tap_p2      = ((half + 2'd2) > numpx_ext) ? numpx_ext : half + 2'd2;
    pass_idx    = (sel_k > numpx_ext) ? numpx_ext : sel_k;
    p0_s        = buf_q[IW'(tap_m1)];
    p1_s        = buf_q[IW'(tap_0)];
    p2_s        = buf_q[IW'(tap_p1)];
    p3_s        = buf_q[IW'(tap_p2)];
    next_sample = !use_up_q ? buf_q[IW'(pass_idx)] : (sel_k[0] ? filt_y : p1_s);
  end

  intra_upsample_filter #(
    .BITDEPTH(BITDEPTH)
  ) u_filter (
    .p0(p0_s),
    .p1(p1_s),
    .p2(p2_s),
    .p3(p3_s),
    .y (filt_y)
  );

  always_comb begin
    state_d     = state_q;
    ft_d        = ft_q;
    w_d         = w_q;
    h_d         = h_q;
    delta_d     = delta_q;
    numpx_d     = numpx_q;
    use_up_d    = use_up_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((numPx == '0) || ({1'b0, numPx} > MAXN)) begin
            err_d = 1'b1;
          end else begin
            ft_d     = filterType;
            w_d      = w;
            h_d      = h;
            delta_d  = delta;
            numpx_d  = numPx;
            use_up_d = 1'b0;
            state_d  = DECIDE;
          end
        end
      end
      DECIDE: begin
        use_up_d = decide_up;
        cnt_d    = '0;
        state_d  = LOAD;
      end
      LOAD: begin
        if (in_valid) begin
          buf_d[IW'(cnt_q)] = in_data;
          cnt_d             = cnt_q + 1'b1;
          if (cnt_q == numpx_ext) begin
            state_d     = EMIT;
            k_d         = '0;
            out_valid_d = 1'b1;
            out_data_d  = next_sample;
            out_last_d  = 1'b0;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (k_q == last_k) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            k_d        = k_q + 1'b1;
            out_data_d = next_sample;
            out_last_d = ((k_q + 1'b1) == last_k);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ft_q        <= 1'b0;
      w_q         <= '0;
      h_q         <= '0;
      delta_q     <= '0;
      numpx_q     <= '0;
      use_up_q    <= 1'b0;
      cnt_q       <= '0;
      k_q         <= '0;
      buf_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ft_q        <= ft_d;
      w_q         <= w_d;
      h_q         <= h_d;
      delta_q     <= delta_d;
      numpx_q     <= numpx_d;
      use_up_q    <= use_up_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Upsampling beyond 16 edge pixels is outside AV1 but still executes.
  cover property (@(posedge clk) disable iff (rst)
    (state_q == DECIDE) && decide_up && (numpx_q > DIM_W'(16)));

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign useUpsample = use_up_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
